// File: rtl/spart_fifo.sv
// spart_fifo: register-mapped UART with TX and RX FIFOs.
// A single 8-bit tri-state bus gives access to data, status/control and the
// 16-bit baud divisor. Each direction latches divisor and framing settings at
// frame start, so reprogramming never disturbs a frame already on the wire.

// Circular buffer with one extra pointer bit to tell full from empty.
module spart_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Read/write pointers advance with natural wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop_ok)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage holds data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

module spart_fifo #(
  parameter int          DATA_BITS  = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'h0145
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // A bit period shorter than two clocks cannot be split at mid-bit.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

  // Bus decode
  logic       acc_wr, acc_rd, status_rd;
  logic [2:0] ctrl;        // {two_stop, parity_odd, parity_en}
  logic [15:0] divisor, div_eff;
  logic [7:0] rd_data;
  logic       overrun, parity_err, framing_err;

  assign acc_wr    = iocs & ~iorw;
  assign acc_rd    = iocs & iorw;
  assign status_rd = acc_rd && (ioaddr == 2'b01);
  assign div_eff   = clamp_div(divisor);

  // FIFOs
  logic                 tx_push, tx_pop, tx_empty, tx_full;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_push, rx_pop, rx_empty, rx_full;
  logic [DATA_BITS-1:0] rx_head, rx_sh;

  assign tx_push = acc_wr && (ioaddr == 2'b00);
  assign rx_pop  = acc_rd && (ioaddr == 2'b00) && !rx_empty;

  spart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop),
    .din(databus[DATA_BITS-1:0]), .dout(tx_head), .empty(tx_empty), .full(tx_full)
  );

  spart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
    .din(rx_sh), .dout(rx_head), .empty(rx_empty), .full(rx_full)
  );

  assign rda = ~rx_empty;
  assign tbr = ~tx_full;

  // Control and divisor registers, written from the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl    <= 3'b000;
      divisor <= DIV_RESET;
    end else if (acc_wr) begin
      case (ioaddr)
        2'b01:   ctrl          <= databus[2:0];
        2'b10:   divisor[7:0]  <= databus;
        2'b11:   divisor[15:8] <= databus;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- TX
  state_t               tx_state, tx_state_d;
  logic [15:0]          tx_cnt, tx_div;
  logic [3:0]           tx_bit;
  logic [2:0]           tx_ctrl;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par, tx_tick, tx_last_data, tx_last_stop, tx_busy;

  assign tx_tick      = (tx_cnt == 16'd0);
  assign tx_last_data = (tx_bit == 4'(DATA_BITS - 1));
  assign tx_last_stop = (tx_bit == {3'b000, tx_ctrl[2]});

  // TX state register; frame settings are latched when a byte is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= 16'd0;
      tx_div   <= 16'd2;
      tx_bit   <= 4'd0;
      tx_ctrl  <= 3'b000;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_d;
      if (tx_pop) begin
        tx_cnt  <= div_eff - 16'd1;
        tx_div  <= div_eff;
        tx_ctrl <= ctrl;
        tx_bit  <= 4'd0;
        tx_par  <= (^tx_head) ^ ctrl[1];
      end else begin
        tx_cnt <= tx_tick ? tx_div - 16'd1 : tx_cnt - 16'd1;
        if (tx_tick) tx_bit <= (tx_state_d != tx_state) ? 4'd0 : tx_bit + 4'd1;
      end
    end
  end

  // TX next state; a byte is popped from IDLE or straight out of the last stop bit.
  always_comb begin
    tx_state_d = tx_state;
    tx_pop     = 1'b0;
    case (tx_state)
      S_IDLE:   if (!tx_empty) begin
                  tx_state_d = S_START;
                  tx_pop     = 1'b1;
                end
      S_START:  if (tx_tick) tx_state_d = S_DATA;
      S_DATA:   if (tx_tick && tx_last_data) tx_state_d = tx_ctrl[0] ? S_PARITY : S_STOP;
      S_PARITY: if (tx_tick) tx_state_d = S_STOP;
      S_STOP:   if (tx_tick && tx_last_stop) begin
                  if (!tx_empty) begin
                    tx_state_d = S_START;
                    tx_pop     = 1'b1;
                  end else begin
                    tx_state_d = S_IDLE;
                  end
                end
      default:  tx_state_d = S_IDLE;
    endcase
  end

  // TX line level decoded from the registered state, so reset drives it high at once.
  always_comb begin
    txd = 1'b1;
    case (tx_state)
      S_START:  txd = 1'b0;
      S_DATA:   txd = tx_sh[0];
      S_PARITY: txd = tx_par;
      default:  txd = 1'b1;
    endcase
  end

  assign tx_busy = (tx_state != S_IDLE) || !tx_empty;

  // TX shift register, LSB leaves first.
  always_ff @(posedge clk) begin
    if (tx_pop) tx_sh <= tx_head;
    else if (tx_state == S_DATA && tx_tick) tx_sh <= tx_sh >> 1;
  end

  // ---------------------------------------------------------------- RX
  state_t      rx_state, rx_state_d;
  logic [15:0] rx_cnt, rx_div;
  logic [3:0]  rx_bit;
  logic [2:0]  rx_ctrl;
  logic        rx_meta, rx_s, rx_prev, rx_fall, rx_tick, rx_last_data, rx_last_stop;
  logic        frame_evt, par_evt, ovr_evt;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign rx_fall      = rx_prev & ~rx_s;
  assign rx_tick      = (rx_cnt == 16'd0);
  assign rx_last_data = (rx_bit == 4'(DATA_BITS - 1));
  assign rx_last_stop = (rx_bit == {3'b000, rx_ctrl[2]});

  // RX state register; the first wait is half a bit so samples land mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= 16'd0;
      rx_div   <= 16'd2;
      rx_bit   <= 4'd0;
      rx_ctrl  <= 3'b000;
    end else begin
      rx_state <= rx_state_d;
      if (rx_state == S_IDLE && rx_fall) begin
        rx_cnt  <= (div_eff >> 1) - 16'd1;
        rx_div  <= div_eff;
        rx_ctrl <= ctrl;
        rx_bit  <= 4'd0;
      end else begin
        rx_cnt <= rx_tick ? rx_div - 16'd1 : rx_cnt - 16'd1;
        if (rx_tick) rx_bit <= (rx_state_d != rx_state) ? 4'd0 : rx_bit + 4'd1;
      end
    end
  end

  // RX next state and per-sample events.
  always_comb begin
    rx_state_d = rx_state;
    rx_push    = 1'b0;
    frame_evt  = 1'b0;
    par_evt    = 1'b0;
    case (rx_state)
      S_IDLE:   if (rx_fall) rx_state_d = S_START;
      S_START:  if (rx_tick) rx_state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (rx_tick && rx_last_data) rx_state_d = rx_ctrl[0] ? S_PARITY : S_STOP;
      S_PARITY: if (rx_tick) begin
                  rx_state_d = S_STOP;
                  par_evt    = ((^rx_sh) ^ rx_s) != rx_ctrl[1];
                end
      S_STOP:   if (rx_tick) begin
                  if (!rx_s) begin
                    frame_evt  = 1'b1;
                    rx_state_d = S_IDLE;
                  end else if (rx_last_stop) begin
                    rx_push    = 1'b1;
                    rx_state_d = S_IDLE;
                  end
                end
      default:  rx_state_d = S_IDLE;
    endcase
  end

  assign ovr_evt = rx_push & rx_full & ~rx_pop;

  // RX shift register, first sampled bit ends up in the LSB.
  always_ff @(posedge clk) begin
    if (rx_state == S_DATA && rx_tick) rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
  end

  // Sticky error flags; a new event beats the clear from a status read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun     <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      overrun     <= ovr_evt   | (overrun     & ~status_rd);
      parity_err  <= par_evt   | (parity_err  & ~status_rd);
      framing_err <= frame_evt | (framing_err & ~status_rd);
    end
  end

  // Read-data multiplexer.
  always_comb begin
    rd_data = 8'h00;
    case (ioaddr)
      2'b00:   if (!rx_empty) rd_data[DATA_BITS-1:0] = rx_head;
      2'b01:   rd_data = {overrun, parity_err, framing_err, tx_busy, tx_full, rx_full, tbr, rda};
      2'b10:   rd_data = divisor[7:0];
      default: rd_data = divisor[15:8];
    endcase
  end

  assign databus = acc_rd ? rd_data : 8'hzz;
endmodule

// File: tb/tb_spart_fifo.sv
// Testbench for spart_fifo: table of RX frames plus hand-written TX, overrun
// and reset sequences; TX and RX bytes are tracked in scoreboard queues.
module tb_spart_fifo;
  localparam int FIFO_DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic       rxd = 1'b1;
  logic       drv_en = 1'b0;
  logic [7:0] drv = 8'h00;
  wire  [7:0] databus;
  wire        rda, tbr, txd;

  assign databus = drv_en ? drv : 8'hzz;

  spart_fifo dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         div_cur = 16'h0145;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  typedef struct {
    logic [7:0] data;
    logic [2:0] ctrl;
    bit         bad_par;
    bit         bad_stop;
    logic [7:0] status;
  } rx_vec_t;

  rx_vec_t vec[7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv = d; drv_en = 1'b1;
    @(negedge clk);
    iocs = 1'b0; drv_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #2 d = databus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic set_div(input logic [15:0] d);
    wr(2'b10, d[7:0]);
    wr(2'b11, d[15:8]);
    div_cur = int'(d);
  endtask

  // Bit sequence of one frame; bad_stop forces the last stop bit low.
  function automatic int make_frame(input logic [7:0] d, input logic [2:0] c,
                                    input bit bad_par, input bit bad_stop,
                                    output logic [11:0] fr);
    int n;
    fr = '1;
    fr[0] = 1'b0;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      fr[n] = d[i];
      n++;
    end
    if (c[0]) begin
      fr[n] = (^d) ^ c[1] ^ bad_par;
      n++;
    end
    fr[n] = 1'b1;
    n++;
    if (c[2]) begin
      fr[n] = 1'b1;
      n++;
    end
    if (bad_stop) fr[n-1] = 1'b0;
    return n;
  endfunction

  // Checks every clock of the next frame on txd, starting at the next negedge.
  task automatic tx_expect(input logic [2:0] c);
    logic [7:0]  d;
    logic [11:0] fr;
    int          n;
    int          bad;
    if (tx_q.size() == 0) begin
      check("tx_scoreboard_empty", 16'd1, 16'd0);
      return;
    end
    d   = tx_q.pop_front();
    n   = make_frame(d, c, 1'b0, 1'b0, fr);
    bad = 0;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < div_cur; k++) begin
        @(negedge clk);
        if (txd !== fr[b]) bad++;
      end
    end
    check($sformatf("tx_frame_%02h_bad_samples", d), 16'(bad), 16'd0);
  endtask

  task automatic rx_drive(input logic [7:0] d, input logic [2:0] c,
                          input bit bad_par, input bit bad_stop);
    logic [11:0] fr;
    int          n;
    n = make_frame(d, c, bad_par, bad_stop, fr);
    for (int b = 0; b < n; b++) begin
      rxd = fr[b];
      repeat (div_cur) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (2 * div_cur) @(negedge clk);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    int         idle_bad;

    vec[0] = '{8'h3C, 3'b011, 1'b0, 1'b0, 8'h03};
    vec[1] = '{8'h00, 3'b000, 1'b0, 1'b0, 8'h03};
    vec[2] = '{8'hFF, 3'b001, 1'b0, 1'b0, 8'h03};
    vec[3] = '{8'h81, 3'b101, 1'b0, 1'b0, 8'h03};
    vec[4] = '{8'h5A, 3'b011, 1'b1, 1'b0, 8'h43};
    vec[5] = '{8'h96, 3'b000, 1'b0, 1'b1, 8'h22};
    vec[6] = '{8'h7E, 3'b100, 1'b0, 1'b1, 8'h22};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", 16'(txd), 16'd1);
    check("rst_rda", 16'(rda), 16'd0);
    check("rst_tbr", 16'(tbr), 16'd1);
    rst = 1'b0;
    rd(2'b01, r); check("rst_status", 16'(r), 16'h02);
    rd(2'b10, r); check("rst_div_lo", 16'(r), 16'h45);
    rd(2'b11, r); check("rst_div_hi", 16'(r), 16'h01);
    rd(2'b00, r); check("empty_data_read", 16'(r), 16'h00);

    // Single 8N1 frame at divisor 4
    set_div(16'd4);
    wr(2'b01, 8'h00);
    tx_q.push_back(8'hA5);
    wr(2'b00, 8'hA5);
    check("txd_high_before_start", 16'(txd), 16'd1);
    check("tbr_one_byte", 16'(tbr), 16'd1);
    tx_expect(3'b000);
    check("tbr_after_frame", 16'(tbr), 16'd1);
    repeat (4) @(negedge clk);

    // Back-to-back writes: the first byte moves to the shifter one clock after
    // its write, so FIFO_DEPTH+1 writes fill the FIFO and one more is dropped.
    fork
      begin
        for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
          if (i <= FIFO_DEPTH) tx_q.push_back(8'hC0 + 8'(i));
          wr(2'b00, 8'hC0 + 8'(i));
          if (i == FIFO_DEPTH - 1) check("tbr_before_full", 16'(tbr), 16'd1);
          if (i >= FIFO_DEPTH) check($sformatf("tbr_full_after_write_%0d", i), 16'(tbr), 16'd0);
        end
      end
      begin
        @(negedge clk);
        for (int f = 0; f <= FIFO_DEPTH; f++) tx_expect(3'b000);
      end
    join
    check("tx_scoreboard_drained", 16'(tx_q.size()), 16'd0);
    idle_bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) idle_bad++;
    end
    check("txd_idle_after_burst", 16'(idle_bad), 16'd0);
    check("tbr_after_burst", 16'(tbr), 16'd1);

    // RX frame table at divisor 16
    set_div(16'd16);
    for (int v = 0; v < 7; v++) begin
      wr(2'b01, {5'b0, vec[v].ctrl});
      if (!vec[v].bad_stop) rx_q.push_back(vec[v].data);
      rx_drive(vec[v].data, vec[v].ctrl, vec[v].bad_par, vec[v].bad_stop);
      check($sformatf("rx%0d_rda", v), 16'(rda), 16'(vec[v].status[0]));
      rd(2'b01, r);
      check($sformatf("rx%0d_status", v), 16'(r), 16'(vec[v].status));
      if (vec[v].status[0]) begin
        rd(2'b00, r);
        if (rx_q.size() == 0) check($sformatf("rx%0d_scoreboard", v), 16'd1, 16'd0);
        else check($sformatf("rx%0d_data", v), 16'(r), 16'(rx_q.pop_front()));
        check($sformatf("rx%0d_rda_after_read", v), 16'(rda), 16'd0);
      end
    end
    rd(2'b01, r); check("sticky_cleared", 16'(r), 16'h02);

    // Quarter-bit glitch: false start, nothing pushed, no error
    wr(2'b01, 8'h00);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_rda", 16'(rda), 16'd0);
    rd(2'b01, r); check("glitch_status", 16'(r), 16'h02);

    // Overrun: FIFO_DEPTH+1 frames with no reads
    set_div(16'd8);
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      if (i < FIFO_DEPTH) rx_q.push_back(8'(i * 37 + 1));
      rx_drive(8'(i * 37 + 1), 3'b000, 1'b0, 1'b0);
    end
    check("ovr_rda", 16'(rda), 16'd1);
    rd(2'b01, r); check("ovr_status", 16'(r), 16'h87);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      rd(2'b00, r);
      if (rx_q.size() == 0) check("ovr_scoreboard", 16'd1, 16'd0);
      else check($sformatf("ovr_data_%0d", i), 16'(r), 16'(rx_q.pop_front()));
    end
    rd(2'b01, r); check("ovr_cleared_status", 16'(r), 16'h02);

    // Reset in the middle of a TX frame and an RX frame
    set_div(16'd16);
    wr(2'b00, 8'h55);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    check("txd_low_mid_frame", 16'(txd), 16'd0);
    #2 rst = 1'b1;
    #1;
    check("txd_async_rst", 16'(txd), 16'd1);
    check("tbr_async_rst", 16'(tbr), 16'd1);
    check("rda_async_rst", 16'(rda), 16'd0);
    @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    div_cur = 16'h0145;
    repeat (40) @(negedge clk);
    check("post_rst_txd", 16'(txd), 16'd1);
    check("post_rst_rda", 16'(rda), 16'd0);
    rd(2'b01, r); check("post_rst_status", 16'(r), 16'h02);
    rd(2'b10, r); check("post_rst_div_lo", 16'(r), 16'h45);
    rd(2'b11, r); check("post_rst_div_hi", 16'(r), 16'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spart_fifo.md
SPART_FIFO -- requirements
Module: spart_fifo

Interface
REQ-001 Parameter DATA_BITS, 8, character length in bits; legal range 5..8.
REQ-002 Parameter FIFO_DEPTH, 8, entries per TX and RX FIFO; power of two, 2..64.
REQ-003 Parameter DIV_RESET, 16'h0145, baud divisor loaded at reset (clocks per bit).
REQ-004 Port clk, input, 1, single clock; all state SHALL be on its rising edge.
REQ-005 Port rst, input, 1, reset; asynchronous and active-high.
REQ-006 Port iocs, input, 1, chip select; one register access per cycle while high.
REQ-007 Port iorw, input, 1, 1 = read (block drives databus), 0 = write (driver drives databus).
REQ-008 Port ioaddr, input, 2, 00 data, 01 status/control, 10 divisor low, 11 divisor high.
REQ-009 Port databus, inout, 8, driven by block only when iocs & iorw, else high-Z.
REQ-010 Port rda, output, 1, RX FIFO not empty.
REQ-011 Port tbr, output, 1, TX FIFO not full.
REQ-012 Port txd, output, 1, serial out; idle high.
REQ-013 Port rxd, input, 1, serial in; asynchronous, idle high.

Function
REQ-014 Write addr 00: push databus[DATA_BITS-1:0] to TX FIFO; when full, the write is dropped and no state changes.
REQ-015 Read addr 00: return RX FIFO head, zero-extended to 8 bits, and pop; when empty, return 8'h00 without popping.
REQ-016 Read addr 01: return {overrun, parity_err, framing_err, tx_busy, tx_full, rx_full, tbr, rda}.
REQ-017 A read of addr 01 SHALL clear the three sticky error bits the cycle after the read; an error event in that same cycle SHALL win (bit stays 1).
REQ-018 Write addr 01: control = databus[2:0] = {two_stop, parity_odd, parity_en}; read-back of control is not provided.
REQ-019 Write addr 10/11: update divisor low/high byte. Reads of 10/11 return the divisor bytes.
REQ-020 Divisor and control changes SHALL take effect only at the next frame start for each direction; an in-flight frame keeps its latched settings.
REQ-021 Effective divisor below 2 SHALL be treated as 2.
REQ-022 A bit period SHALL be exactly divisor clk cycles.
REQ-023 Frame: start(0), DATA_BITS LSB-first, optional parity (even/odd over data), 1 or 2 stop bits(1).
REQ-024 TX FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-025 TX, IDLE with FIFO non-empty: pop and enter START; txd SHALL go low on the clock after the pop.
REQ-026 TX: PARITY is skipped when parity_en=0. After STOP, return to IDLE, or go directly to START if the FIFO is non-empty (back-to-back frames, no idle gap).
REQ-027 rxd SHALL pass through a 2-flop synchroniser reset to 1; all RX decisions use the synchronised value.
REQ-028 RX FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-029 RX, IDLE: on a synchronised 1->0 edge, enter START and wait divisor/2 (integer floor) cycles.
REQ-030 RX, START: if the line is high at mid-start, the start is false; return to IDLE and push nothing.
REQ-031 RX data/parity/stop bits SHALL be sampled every divisor cycles from mid-start; with two_stop=1, both stop bits are checked.
REQ-032 RX parity mismatch: set parity_err; the byte is still pushed.
REQ-033 RX stop bit sampled 0: set framing_err; discard the byte; return to IDLE and re-arm on the next falling edge.
REQ-034 RX push with RX FIFO full: drop the new byte, set overrun, leave FIFO contents unchanged.
REQ-035 Simultaneous push and pop on either FIFO SHALL both take effect; count is unchanged and a full FIFO stays consistent.
REQ-036 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits with natural wrap; full/empty are derived from pointer compare.
REQ-037 rda, tbr, tx_full and rx_full SHALL reflect FIFO state combinationally from registered counts, with no added lag.
REQ-038 tx_busy = TX FSM not IDLE or TX FIFO non-empty.

Reset
REQ-039 On rst high, immediately and independent of clk: txd=1, rda=0, tbr=1, FIFOs empty, both FSMs IDLE, sticky errors 0, control 3'b000, divisor DIV_RESET, synchroniser 1.
REQ-040 Reset mid-frame SHALL abort the frame; no partial byte is pushed; txd returns high without waiting for a clock.

Verification
REQ-041 Divisor 4, 8N1, write 8'hA5 -> txd low for 4 clk starting 1 clk after the write, then bits 1,0,1,0,0,1,0,1 at 4 clk each, then high; tbr stays 1.
REQ-042 Divisor 16, 8O1, drive frame 8'h3C with correct parity on rxd -> rda=1; status read = 8'h03 (tbr and rda set, no errors); data read = 8'h3C; rda returns to 0.
REQ-043 Drive FIFO_DEPTH+1 frames without reading -> rx_full=1, overrun=1; reads return the first FIFO_DEPTH bytes in order; status read then clears overrun.
REQ-044 Drive a frame with stop=0 -> framing_err=1, rda remains 0. Drive a 1/4-bit low glitch -> no push, no error.
REQ-045 Write FIFO_DEPTH+1 bytes back-to-back -> tbr=0 after the FIFO fills; the extra byte is dropped; frames go out with no idle gap.
REQ-046 Assert rst mid-TX and mid-RX -> txd=1 immediately; status reads 8'h02 after reset release (tbr only); divisor reads back DIV_RESET.
